// File: rtl/dtc_vote_accum_if.sv
// rtl/dtc_vote_accum_if.sv - sample input stream, flush and voted output stream of dtc_vote_accum
interface dtc_vote_accum_if #(
  parameter int WIDTH = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec;

  modport master (
    output in_valid, in_vec, flush, out_ready,
    input  in_ready, out_valid, out_vec
  );

  modport slave (
    input  in_valid, in_vec, flush, out_ready,
    output in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/dtc_vote_accum.sv
// rtl/dtc_vote_accum.sv - per-bit majority vote over a fixed window of classifier samples
module dtc_vote_accum #(
  parameter int WIDTH  = 7,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 8
) (
  input logic              clk,
  input logic              rst_n,
  dtc_vote_accum_if.slave  bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [CNT_W-1:0] sample_cnt;
  logic [WIDTH-1:0] vote;
  logic [WIDTH-1:0] out_vec_q;
  logic             out_valid_q;
  logic             accept;
  logic             done;

  assign bus.in_ready  = (state == ACCUM) && rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign done   = accept && !bus.flush && (sample_cnt == CNT_W'(WINDOW - 1));

  // The vote includes the sample being accepted on the completing edge.
  always_comb begin
    vote = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vote[i] = (cnt[i] + CNT_W'(bus.in_vec[i])) > CNT_W'(THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (done) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      sample_cnt  <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
    end else if (state == ACCUM) begin
      if (bus.flush) begin
        for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        sample_cnt <= '0;
      end else if (accept) begin
        for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt[i] + CNT_W'(bus.in_vec[i]);
        sample_cnt <= sample_cnt + 1'b1;
        if (done) begin
          out_vec_q   <= vote;
          out_valid_q <= 1'b1;
        end
      end
    end else if (bus.out_ready) begin
      // Flush is ignored while holding; only the output handshake releases the window.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      sample_cnt  <= '0;
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dtc_vote_accum.sv
// tb/tb_dtc_vote_accum.sv - scoreboard bench for dtc_vote_accum with a window-list reference model
module tb_dtc_vote_accum;
  localparam int WIDTH  = 7;
  localparam int CNT_W  = 8;
  localparam int WINDOW = 4;
  localparam int THRESH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtc_vote_accum_if #(.WIDTH(WIDTH)) bus ();

  dtc_vote_accum #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .WINDOW(WINDOW),
    .THRESH(THRESH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] win [$];
  bit               m_hold = 1'b0;
  logic [WIDTH-1:0] m_out = '0;
  logic [WIDTH-1:0] m_res;
  int               m_n;
  logic [WIDTH-1:0] sb_exp;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: a window is the list of accepted samples; vote by counting ones per bit.
  always @(posedge clk) begin
    if (!rst_n) begin
      win.delete();
      sb_q.delete();
      m_hold = 1'b0;
      m_out  = '0;
    end else if (!m_hold) begin
      if (bus.flush) begin
        win.delete();
      end else if (bus.in_valid) begin
        win.push_back(bus.in_vec);
        if (win.size() == WINDOW) begin
          m_res = '0;
          for (int b = 0; b < WIDTH; b++) begin
            m_n = 0;
            foreach (win[k]) m_n += int'(win[k][b]);
            m_res[b] = (m_n > THRESH);
          end
          m_out  = m_res;
          m_hold = 1'b1;
          sb_q.push_back(m_res);
          win.delete();
        end
      end
    end else if (bus.out_ready) begin
      m_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!m_hold && rst_n));
      chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
      chk("out_vec", 32'(bus.out_vec), 32'(m_out));
      if (bus.out_valid && bus.out_ready && rst_n) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got result %0h required none", bus.out_vec);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("sb_result", 32'(bus.out_vec), 32'(sb_exp));
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit f, input bit o);
    bus.in_valid  = v;
    bus.in_vec    = d;
    bus.flush     = f;
    bus.out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_vec", 32'(bus.out_vec), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    cyc(0, '0, 0, 0);

    // Basic vote
    repeat (3) cyc(1, 7'h7F, 0, 0);
    cyc(1, 7'h00, 0, 0);
    chk("basic_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_vec", 32'(bus.out_vec), 32'h7F);
    chk("basic_ready", 32'(bus.in_ready), 32'd0);
    cyc(0, '0, 0, 1);
    chk("basic_release_valid", 32'(bus.out_valid), 32'd0);
    chk("basic_release_ready", 32'(bus.in_ready), 32'd1);

    // Strict threshold
    cyc(1, 7'h03, 0, 0);
    cyc(1, 7'h03, 0, 0);
    cyc(1, 7'h01, 0, 0);
    cyc(1, 7'h00, 0, 0);
    chk("strict_vec", 32'(bus.out_vec), 32'h01);
    cyc(0, '0, 0, 1);

    // Backpressure, then a window that must start from zero counts
    repeat (4) cyc(1, 7'h0F, 0, 0);
    repeat (5) begin
      cyc(1, 7'h7F, 0, 0);
      chk("bp_vec_stable", 32'(bus.out_vec), 32'h0F);
      chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
    end
    cyc(1, 7'h7F, 0, 1);
    chk("bp_after_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_after_ready", 32'(bus.in_ready), 32'd1);
    cyc(1, 7'h01, 0, 0);
    cyc(1, 7'h01, 0, 0);
    cyc(1, 7'h00, 0, 0);
    cyc(1, 7'h00, 0, 0);
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_next_vec", 32'(bus.out_vec), 32'h00);
    cyc(0, '0, 0, 1);

    // Bubbles and flush
    cyc(1, 7'h7F, 0, 0);
    cyc(0, 7'h7F, 0, 0);
    cyc(0, 7'h7F, 0, 0);
    cyc(1, 7'h7F, 0, 0);
    cyc(1, 7'h7F, 1, 0);
    cyc(1, 7'h55, 0, 0);
    cyc(0, 7'h7F, 0, 0);
    cyc(1, 7'h55, 0, 0);
    cyc(1, 7'h55, 0, 0);
    chk("flush_early_valid", 32'(bus.out_valid), 32'd0);
    cyc(1, 7'h55, 0, 0);
    chk("flush_valid", 32'(bus.out_valid), 32'd1);
    chk("flush_vec", 32'(bus.out_vec), 32'h55);
    cyc(0, '0, 0, 1);

    // Flush while holding a result
    repeat (4) cyc(1, 7'h2A, 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);
    chk("hold_flush_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_flush_vec", 32'(bus.out_vec), 32'h2A);
    cyc(0, '0, 0, 1);
    chk("hold_keep_vec", 32'(bus.out_vec), 32'h2A);

    // Mid-window reset
    repeat (3) cyc(1, 7'h7F, 0, 0);
    rst_n = 1'b0;
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_vec", 32'(bus.out_vec), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    repeat (3) cyc(1, 7'h7F, 0, 0);
    chk("midrst_early_valid", 32'(bus.out_valid), 32'd0);
    cyc(1, 7'h7F, 0, 0);
    chk("midrst_full_valid", 32'(bus.out_valid), 32'd1);
    chk("midrst_full_vec", 32'(bus.out_vec), 32'h7F);
    cyc(0, '0, 0, 1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cyc($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 1) == 1);
    end

    rst_n = 1'b1;
    repeat (3) cyc(0, '0, 0, 1);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
